bsf_stream_mem_writer: RTL and testbench

- Upstream feeder for the 1024 x 32 single-port on-chip RAM: an Avalon-MM write master.
- Accepts a byte stream (valid/ready/last) and packs bytes little-endian into 32-bit words.
- Writes each word to consecutive word addresses from a programmable base.
- Used to load hash-input blocks into on-chip memory before the compute stage reads them.

---
 rtl/bsf_pkg.sv | 31 +++
 rtl/bsf_byte_packer.sv | 56 +++++
 rtl/bsf_stream_mem_writer.sv | 140 ++++++++++++++
 tb/tb_bsf_stream_mem_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsf_pkg.sv
// Shared definitions for the byte-stream memory writer.
//   - Default widths of the word address, memory word and word-count fields.
//   - State encoding of the transfer FSM.
//   - Lane count and a helper that builds the byteenable for a partial word.
package bsf_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int CNT_W_DEF      = 11;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byteenable for a word whose last byte landed on lane k: lanes 0..k set.
    function automatic logic [BYTES_PER_WORD-1:0] be_mask(input logic [1:0] lane);
        logic [BYTES_PER_WORD-1:0] mask;
        mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i <= int'(lane)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/bsf_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, srst   : clock and synchronous active-high reset
//   byte_valid  : a byte is accepted this cycle
//   byte_data   : the accepted byte
//   byte_last   : the accepted byte ends the stream
//   word        : pack register merged with the current byte (combinational)
//   be          : byteenable of that word, lanes 0..current lane
//   word_valid  : the word completes this cycle (lane 3 or last byte)
module bsf_byte_packer
    import bsf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic                      byte_last,
    output logic [DATA_W-1:0]         word,
    output logic [BYTES_PER_WORD-1:0] be,
    output logic                      word_valid
);

    logic [1:0]        lane_reg;
    logic [DATA_W-1:0] pack_reg;

    // The word presented on completion already contains the byte arriving
    // this cycle, so the top can capture it without an extra cycle.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word[8*gi +: 8] = (byte_valid && lane_reg == 2'(gi))
                                     ? byte_data : pack_reg[8*gi +: 8];
        end
    endgenerate

    assign be         = be_mask(lane_reg);
    assign word_valid = byte_valid && (lane_reg == 2'd3 || byte_last);

    // Clearing on completion keeps unused upper lanes of a partial word at 0.
    always_ff @(posedge clk) begin
        if (srst) begin
            lane_reg <= '0;
            pack_reg <= '0;
        end else if (byte_valid) begin
            if (word_valid) begin
                lane_reg <= '0;
                pack_reg <= '0;
            end else begin
                lane_reg <= lane_reg + 2'd1;
                pack_reg <= word;
            end
        end
    end

endmodule

// File: rtl/bsf_stream_mem_writer.sv
// Avalon-MM write master that loads a byte stream into on-chip RAM.
// Bytes are packed little-endian into 32-bit words and written to
// consecutive word addresses starting at base_addr, up to max_words words.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : launches a transfer from IDLE (latches base/limit)
//   base_addr, max_words: first word address and word limit
//   s_data/s_valid/s_last/s_ready : byte stream input
//   avm_*               : memory write port (no waitrequest)
//   busy, done          : transfer in progress / one-cycle completion pulse
//   words_written       : words issued in the current or last transfer
//   overflow            : sticky, bytes were dropped at the limit
module bsf_stream_mem_writer
    import bsf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          max_words,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write,
    output logic [BYTES_PER_WORD-1:0] avm_byteenable,
    output logic [DATA_W-1:0]         avm_writedata,
    output logic                      avm_clken,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          words_written,
    output logic                      overflow
);

    state_t                    state_reg, state_next;
    logic [ADDR_W-1:0]         base_reg;
    logic [CNT_W-1:0]          max_reg;
    logic [CNT_W-1:0]          words_reg;
    logic                      overflow_reg;
    logic                      pend_reg;
    logic [ADDR_W-1:0]         hold_addr_reg;
    logic [DATA_W-1:0]         hold_data_reg;
    logic [BYTES_PER_WORD-1:0] hold_be_reg;

    logic                      accept;
    logic [DATA_W-1:0]         pk_word;
    logic [BYTES_PER_WORD-1:0] pk_be;
    logic                      pk_word_valid;
    logic [CNT_W:0]            used_words;
    logic                      full;
    logic                      commit;
    logic [ADDR_W-1:0]         wr_addr;

    assign s_ready = (state_reg == RUN);
    assign accept  = s_valid && s_ready;

    bsf_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .srst       (reset),
        .byte_valid (accept),
        .byte_data  (s_data),
        .byte_last  (s_last),
        .word       (pk_word),
        .be         (pk_be),
        .word_valid (pk_word_valid)
    );

    // The limit counts the word sitting in the holding register too, since
    // it has been committed but words_written has not caught up yet.
    assign used_words = {1'b0, words_reg} + (CNT_W+1)'(pend_reg);
    assign full       = (used_words >= {1'b0, max_reg});
    assign commit     = pk_word_valid && !full;
    assign wr_addr    = base_reg + words_reg[ADDR_W-1:0] + ADDR_W'(pend_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && s_last) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            max_reg       <= '0;
            words_reg     <= '0;
            overflow_reg  <= 1'b0;
            pend_reg      <= 1'b0;
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
            hold_be_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                base_reg     <= base_addr;
                max_reg      <= max_words;
                words_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (pend_reg) begin
                    words_reg <= words_reg + CNT_W'(1);
                end
                if (accept && full) begin
                    overflow_reg <= 1'b1;
                end
            end
            // Holding register frees the packer, so the stream never stalls.
            pend_reg      <= commit;
            hold_addr_reg <= commit ? wr_addr : '0;
            hold_data_reg <= commit ? pk_word : '0;
            hold_be_reg   <= commit ? pk_be   : '0;
        end
    end

    // A write still held when reset arrives is abandoned, not sent to memory.
    assign avm_write      = pend_reg && !reset;
    assign avm_chipselect = pend_reg && !reset;
    assign avm_address    = hold_addr_reg;
    assign avm_writedata  = hold_data_reg;
    assign avm_byteenable = hold_be_reg;
    assign avm_clken      = 1'b1;
    assign busy           = (state_reg == RUN) || (state_reg == FLUSH);
    assign done           = (state_reg == DONE);
    assign words_written  = words_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_bsf_stream_mem_writer.sv
// Directed bench for bsf_stream_mem_writer: captured writes are compared
// against hand-computed addresses, data and byteenables.
module tb_bsf_stream_mem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] max_words;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [9:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_clken;
    logic        busy;
    logic        done;
    logic [10:0] words_written;
    logic        overflow;

    always #5 clk = ~clk;

    bsf_stream_mem_writer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .max_words      (max_words),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_clken      (avm_clken),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .overflow       (overflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_bad    = 0;
    int          wr_n     = 0;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [3:0]  wr_be   [0:63];
    int          wr_cyc  [0:63];
    int          wb;
    int          last_cyc;
    int          done_cyc;
    int          rdy_lows;
    int          gap_at   = -1;
    int          pulse_at = -1;
    bit          done_seen;

    // Write monitor: one line per memory write.
    always @(negedge clk) begin
        if (avm_write && avm_chipselect && wr_n < 64) begin
            wr_addr[wr_n] = avm_address;
            wr_data[wr_n] = avm_writedata;
            wr_be[wr_n]   = avm_byteenable;
            wr_cyc[wr_n]  = cyc;
            $display("write addr=%h data=%h be=%b", avm_address, avm_writedata, avm_byteenable);
            wr_n = wr_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] m);
        start     = 1'b1;
        base_addr = b;
        max_words = m;
        @(posedge clk); #1;
        start    = 1'b0;
        wb       = wr_n;
        rdy_lows = 0;
    endtask

    task automatic send(input int n, input logic [7:0] first, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = first + 8'(i);
            s_last  = with_last && (i == n - 1);
            start   = (i == pulse_at);
            if (i == pulse_at) base_addr = 10'h100;
            @(negedge clk);
            if (!s_ready) rdy_lows++;
            if (s_last) last_cyc = cyc;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done();
        done_seen = 1'b0;
        done_cyc  = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("done_seen", 32'(done_seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; max_words = '0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_write", 32'(avm_write), 32'd0);
        check_eq("rst_cs",    32'(avm_chipselect), 32'd0);
        check_eq("rst_clken", 32'(avm_clken), 32'd1);
        check_eq("rst_ready", 32'(s_ready), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_ww",    32'(words_written), 32'd0);
        check_eq("rst_ovf",   32'(overflow), 32'd0);
        check_eq("rst_addr",  32'(avm_address), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two full words.
        do_start(10'h010, 11'd4);
        send(8, 8'h01, 1'b1);
        wait_done();
        check_eq("t1_nwr",   wr_n - wb, 2);
        check_eq("t1_addr0", 32'(wr_addr[wb]), 32'h010);
        check_eq("t1_data0", wr_data[wb], 32'h04030201);
        check_eq("t1_be0",   32'(wr_be[wb]), 32'hF);
        check_eq("t1_addr1", 32'(wr_addr[wb+1]), 32'h011);
        check_eq("t1_data1", wr_data[wb+1], 32'h08070605);
        check_eq("t1_be1",   32'(wr_be[wb+1]), 32'hF);
        check_eq("t1_ww",    32'(words_written), 32'd2);
        check_eq("t1_ovf",   32'(overflow), 32'd0);
        check_eq("t1_wlat",  wr_cyc[wb+1] - last_cyc, 1);
        check_eq("t1_dlat",  done_cyc - last_cyc, 2);
        check_eq("t1_busy",  32'(busy), 32'd0);

        // Partial final word, with an idle gap mid-stream.
        do_start(10'h020, 11'd10);
        gap_at = 5;
        send(6, 8'hA0, 1'b1);
        gap_at = -1;
        wait_done();
        check_eq("t2_nwr",   wr_n - wb, 2);
        check_eq("t2_addr0", 32'(wr_addr[wb]), 32'h020);
        check_eq("t2_data0", wr_data[wb], 32'hA3A2A1A0);
        check_eq("t2_addr1", 32'(wr_addr[wb+1]), 32'h021);
        check_eq("t2_data1", wr_data[wb+1], 32'h0000A5A4);
        check_eq("t2_be1",   32'(wr_be[wb+1]), 32'h3);
        check_eq("t2_ww",    32'(words_written), 32'd2);

        // Address wrap at the top of memory.
        do_start(10'h3FF, 11'd8);
        send(8, 8'h11, 1'b1);
        wait_done();
        check_eq("t3_nwr",   wr_n - wb, 2);
        check_eq("t3_addr0", 32'(wr_addr[wb]), 32'h3FF);
        check_eq("t3_addr1", 32'(wr_addr[wb+1]), 32'h000);
        check_eq("t3_data1", wr_data[wb+1], 32'h18171615);

        // Limit of one word: the rest drains and is dropped.
        do_start(10'h030, 11'd1);
        send(8, 8'h21, 1'b1);
        wait_done();
        check_eq("t4_rdylow", rdy_lows, 0);
        check_eq("t4_nwr",    wr_n - wb, 1);
        check_eq("t4_addr0",  32'(wr_addr[wb]), 32'h030);
        check_eq("t4_data0",  wr_data[wb], 32'h24232221);
        check_eq("t4_be0",    32'(wr_be[wb]), 32'hF);
        check_eq("t4_ovf",    32'(overflow), 32'd1);
        check_eq("t4_ww",     32'(words_written), 32'd1);

        // Limit of zero words.
        do_start(10'h040, 11'd0);
        send(3, 8'h31, 1'b1);
        wait_done();
        check_eq("t5_nwr", wr_n - wb, 0);
        check_eq("t5_ovf", 32'(overflow), 32'd1);
        check_eq("t5_ww",  32'(words_written), 32'd0);

        // start while busy is ignored.
        do_start(10'h050, 11'd8);
        pulse_at = 2;
        send(8, 8'h41, 1'b1);
        pulse_at = -1;
        wait_done();
        check_eq("t6_nwr",   wr_n - wb, 2);
        check_eq("t6_addr0", 32'(wr_addr[wb]), 32'h050);
        check_eq("t6_addr1", 32'(wr_addr[wb+1]), 32'h051);
        check_eq("t6_data0", wr_data[wb], 32'h44434241);

        // Reset while the first word is pending.
        do_start(10'h060, 11'd4);
        send(4, 8'h51, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("t7_wr_now", 32'(avm_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("t7_nwr",   wr_n - wb, 0);
        check_eq("t7_ready", 32'(s_ready), 32'd0);
        check_eq("t7_busy",  32'(busy), 32'd0);
        check_eq("t7_ww",    32'(words_written), 32'd0);
        check_eq("t7_wr",    32'(avm_write), 32'd0);
        check_eq("t7_data",  avm_writedata, 32'd0);
        check_eq("t7_clken", 32'(avm_clken), 32'd1);

        // Fresh transfer after the aborted one starts from a clean packer.
        do_start(10'h070, 11'd4);
        send(4, 8'h61, 1'b1);
        wait_done();
        check_eq("t8_nwr",   wr_n - wb, 1);
        check_eq("t8_addr0", 32'(wr_addr[wb]), 32'h070);
        check_eq("t8_data0", wr_data[wb], 32'h64636261);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
